// File: rtl/trap_ctrl.sv
// Machine-mode trap entry (ecall, optional timer irq) and mret sequencer; owns mstatus.MIE/MPIE.
// Define TRAP_CTRL_IRQ_EN to compile in the machine-timer interrupt path.
module trap_ctrl #(
  parameter logic [63:0] MTVEC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_ecall,
  input  logic        ex_mret,
  input  logic [63:0] ex_pc,
  input  logic        irq_timer,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  input  logic        sw_csr_wen,
  input  logic [11:0] sw_csr_id,
  input  logic [63:0] sw_csr_wdata,
  output logic        stall,
  output logic        csr_wen,
  output logic [11:0] csr_id,
  output logic [63:0] csr_wdata,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [63:0] mstatus_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAVE_EPC   = 3'd1,
    SAVE_CAUSE = 3'd2,
    REDIRECT   = 3'd3,
    RET        = 3'd4
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [63:0] CAUSE_IRQ   = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL = 64'h0000_0000_0000_000B;

  state_t      r_state;
  logic        r_mie;
  logic        r_mpie;
  logic [63:0] r_epc;
  logic [63:0] r_cause;

  logic w_idle_req;
  logic w_irq;
  logic w_take_irq;
  logic w_take_ecall;
  logic w_take_mret;
  logic w_accept;
  logic w_sw_mstatus;
  logic w_unused_wdata;

`ifdef TRAP_CTRL_IRQ_EN
  assign w_irq = irq_timer & r_mie;
`else
  logic w_unused_irq;
  assign w_unused_irq = irq_timer;
  assign w_irq        = 1'b0;
`endif

  assign w_unused_wdata = ^{sw_csr_wdata[63:8], sw_csr_wdata[6:4], sw_csr_wdata[2:0]};

  assign w_idle_req   = (r_state == IDLE) && ex_valid;
  assign w_take_irq   = w_idle_req && w_irq;
  assign w_take_ecall = w_idle_req && !w_irq && ex_ecall;
  assign w_take_mret  = w_idle_req && !w_irq && !ex_ecall && ex_mret;
  assign w_accept     = w_take_irq || w_take_ecall || w_take_mret;

  assign stall        = w_accept || (r_state != IDLE);
  // A software mstatus write is only honoured while the pipeline is free-running.
  assign w_sw_mstatus = sw_csr_wen && (sw_csr_id == CSR_MSTATUS) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mie   <= 1'b0;
      r_mpie  <= 1'b0;
      r_epc   <= '0;
      r_cause <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_epc <= ex_pc;
            if (!w_take_mret) r_cause <= w_take_irq ? CAUSE_IRQ : CAUSE_ECALL;
            r_state <= w_take_mret ? RET : SAVE_EPC;
          end else if (w_sw_mstatus) begin
            r_mie  <= sw_csr_wdata[3];
            r_mpie <= sw_csr_wdata[7];
          end
        end
        SAVE_EPC: begin
          r_mpie  <= r_mie;
          r_mie   <= 1'b0;
          r_state <= SAVE_CAUSE;
        end
        SAVE_CAUSE: r_state <= REDIRECT;
        REDIRECT:   r_state <= IDLE;
        RET: begin
          r_mie   <= r_mpie;
          r_mpie  <= 1'b1;
          r_state <= IDLE;
        end
        default:    r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    csr_wen        = 1'b0;
    csr_id         = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      SAVE_EPC: begin
        csr_wen   = 1'b1;
        csr_id    = CSR_MEPC;
        csr_wdata = r_epc;
      end
      SAVE_CAUSE: begin
        csr_wen   = 1'b1;
        csr_id    = CSR_MCAUSE;
        csr_wdata = r_cause;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = mtvec_i & MTVEC_ALIGN_MASK;
      end
      RET: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc_i;
      end
      default: ;
    endcase
  end

  // MPP is hard-wired to M-mode; everything else outside MIE/MPIE reads zero.
  always_comb begin
    mstatus_o        = '0;
    mstatus_o[12:11] = 2'b11;
    mstatus_o[7]     = r_mpie;
    mstatus_o[3]     = r_mie;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: ecall entry, mret, irq priority/masking, reset mid-sequence, blocked sw write.
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ecall, ex_mret, irq_timer, sw_csr_wen;
  logic [63:0] ex_pc, mtvec_i, mepc_i, sw_csr_wdata;
  logic [11:0] sw_csr_id;
  logic        stall, csr_wen, redirect_valid;
  logic [11:0] csr_id;
  logic [63:0] csr_wdata, redirect_pc, mstatus_o;

  int n_checks = 0;
  int n_fail   = 0;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
    .ex_pc(ex_pc), .irq_timer(irq_timer), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .sw_csr_wen(sw_csr_wen), .sw_csr_id(sw_csr_id), .sw_csr_wdata(sw_csr_wdata),
    .stall(stall), .csr_wen(csr_wen), .csr_id(csr_id), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mstatus_o(mstatus_o)
  );

  always #5 clk = ~clk;

  task automatic clear_ex();
    ex_valid = 0; ex_ecall = 0; ex_mret = 0; ex_pc = '0; irq_timer = 0;
    sw_csr_wen = 0; sw_csr_id = '0; sw_csr_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; clear_ex();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  // Drive a request at a negedge; leaves the caller at the negedge of cycle 1.
  task automatic issue(input logic ecall, input logic mret, input logic [63:0] pc);
    @(negedge clk);
    ex_valid = 1; ex_ecall = ecall; ex_mret = mret; ex_pc = pc;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL accept_stall: got %b exp 1", stall); end
    @(negedge clk);
    ex_valid = 0; ex_ecall = 0; ex_mret = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_ex(); mtvec_i = '0; mepc_i = '0;
    #12;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", stall); end
    n_checks++; if ({csr_wen, csr_id, csr_wdata} !== '0) begin n_fail++; $display("FAIL rst_csr: got %b %h %h exp 0", csr_wen, csr_id, csr_wdata); end
    n_checks++; if ({redirect_valid, redirect_pc} !== '0) begin n_fail++; $display("FAIL rst_redir: got %b %h exp 0", redirect_valid, redirect_pc); end
    n_checks++; if (mstatus_o !== 64'h1800) begin n_fail++; $display("FAIL rst_mstatus: got %h exp 1800", mstatus_o); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_ecall();
    mtvec_i = 64'h8000_0103;
    issue(1, 0, 64'h8000_0010);
    n_checks++; if ({stall, csr_wen, csr_id, csr_wdata} !== {1'b1, 1'b1, 12'h341, 64'h8000_0010}) begin
      n_fail++; $display("FAIL ecall_epc: got s%b w%b %h %h exp 1 1 341 80000010", stall, csr_wen, csr_id, csr_wdata); end
    @(negedge clk);
    n_checks++; if ({stall, csr_wen, csr_id, csr_wdata} !== {1'b1, 1'b1, 12'h342, 64'hB}) begin
      n_fail++; $display("FAIL ecall_cause: got s%b w%b %h %h exp 1 1 342 b", stall, csr_wen, csr_id, csr_wdata); end
    @(negedge clk);
    n_checks++; if ({stall, csr_wen, redirect_valid, redirect_pc} !== {1'b1, 1'b0, 1'b1, 64'h8000_0100}) begin
      n_fail++; $display("FAIL ecall_redir: got s%b w%b v%b %h exp 1 0 1 80000100", stall, csr_wen, redirect_valid, redirect_pc); end
    @(negedge clk);
    n_checks++; if ({stall, redirect_valid} !== 2'b00) begin n_fail++; $display("FAIL ecall_done: got %b%b exp 00", stall, redirect_valid); end
    n_checks++; if (mstatus_o !== 64'h1800) begin n_fail++; $display("FAIL ecall_mstatus: got %h exp 1800", mstatus_o); end
  endtask

  task automatic test_mret();
    @(negedge clk);
    sw_csr_wen = 1; sw_csr_id = 12'h300; sw_csr_wdata = 64'h8;
    @(negedge clk);
    clear_ex();
    n_checks++; if (mstatus_o !== 64'h1808) begin n_fail++; $display("FAIL sw_write: got %h exp 1808", mstatus_o); end
    issue(1, 0, 64'h8000_0020);
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_checks++; if (mstatus_o !== 64'h1880) begin n_fail++; $display("FAIL entry_mstatus: got %h exp 1880", mstatus_o); end
    mepc_i = 64'h8000_0014;
    issue(0, 1, 64'h8000_0030);
    n_checks++; if ({stall, redirect_valid, redirect_pc} !== {1'b1, 1'b1, 64'h8000_0014}) begin
      n_fail++; $display("FAIL mret_redir: got s%b v%b %h exp 1 1 80000014", stall, redirect_valid, redirect_pc); end
    @(negedge clk);
    n_checks++; if (mstatus_o !== 64'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h exp 1888", mstatus_o); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mret_done: got %b exp 0", stall); end
  endtask

  // New request in the IDLE cycle directly after RET.
  task automatic test_back_to_back();
    mepc_i = 64'h8000_0040;
    issue(0, 1, 64'h8000_0038);
    n_checks++; if (redirect_pc !== 64'h8000_0040) begin n_fail++; $display("FAIL b2b_ret: got %h exp 80000040", redirect_pc); end
    issue(1, 0, 64'h8000_0044);
    n_checks++; if ({csr_id, csr_wdata} !== {12'h341, 64'h8000_0044}) begin
      n_fail++; $display("FAIL b2b_epc: got %h %h exp 341 80000044", csr_id, csr_wdata); end
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_checks++; if (mstatus_o !== 64'h1880) begin n_fail++; $display("FAIL b2b_mstatus: got %h exp 1880", mstatus_o); end
  endtask

  task automatic test_irq_masked();
    do_reset();
    @(negedge clk);
    ex_valid = 1; irq_timer = 1; ex_pc = 64'h8000_0060;
    #1;
    n_checks++; if ({stall, csr_wen} !== 2'b00) begin n_fail++; $display("FAIL masked_accept: got %b%b exp 00", stall, csr_wen); end
    @(negedge clk);
    n_checks++; if ({stall, csr_wen, redirect_valid} !== 3'b000) begin n_fail++; $display("FAIL masked_next: got %b%b%b exp 000", stall, csr_wen, redirect_valid); end
    clear_ex();
  endtask

  task automatic test_irq_priority();
    logic [63:0] exp_cause;
`ifdef TRAP_CTRL_IRQ_EN
    exp_cause = 64'h8000_0000_0000_0007;
`else
    exp_cause = 64'hB;
`endif
    do_reset();
    @(negedge clk);
    sw_csr_wen = 1; sw_csr_id = 12'h300; sw_csr_wdata = 64'h8;
    @(negedge clk);
    clear_ex();
    irq_timer = 1;
    issue(1, 0, 64'h8000_0050);
    n_checks++; if ({csr_id, csr_wdata} !== {12'h341, 64'h8000_0050}) begin
      n_fail++; $display("FAIL irq_epc: got %h %h exp 341 80000050", csr_id, csr_wdata); end
    @(negedge clk);
    n_checks++; if ({csr_id, csr_wdata} !== {12'h342, exp_cause}) begin
      n_fail++; $display("FAIL irq_cause: got %h %h exp 342 %h", csr_id, csr_wdata, exp_cause); end
    irq_timer = 0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (mstatus_o !== 64'h1880) begin n_fail++; $display("FAIL irq_mstatus: got %h exp 1880", mstatus_o); end
  endtask

  task automatic test_reset_mid();
    mtvec_i = 64'h8000_0203;
    issue(1, 0, 64'h8000_0070);
    @(negedge clk);
    n_checks++; if (csr_id !== 12'h342) begin n_fail++; $display("FAIL mid_pre: got %h exp 342", csr_id); end
    #2 rst_n = 0;
    #1;
    n_checks++; if ({stall, csr_wen, csr_id, csr_wdata, redirect_valid} !== '0) begin
      n_fail++; $display("FAIL mid_async: got s%b w%b %h %h v%b exp 0", stall, csr_wen, csr_id, csr_wdata, redirect_valid); end
    n_checks++; if (mstatus_o !== 64'h1800) begin n_fail++; $display("FAIL mid_mstatus: got %h exp 1800", mstatus_o); end
    @(negedge clk); rst_n = 1;
    issue(1, 0, 64'h8000_0080);
    n_checks++; if ({csr_wen, csr_id, csr_wdata} !== {1'b1, 12'h341, 64'h8000_0080}) begin
      n_fail++; $display("FAIL mid_epc: got %b %h %h exp 1 341 80000080", csr_wen, csr_id, csr_wdata); end
    @(negedge clk);
    n_checks++; if (csr_wdata !== 64'hB) begin n_fail++; $display("FAIL mid_cause: got %h exp b", csr_wdata); end
    @(negedge clk);
    n_checks++; if (redirect_pc !== 64'h8000_0200) begin n_fail++; $display("FAIL mid_redir: got %h exp 80000200", redirect_pc); end
    @(negedge clk);
  endtask

  // Software mstatus write held through accept and the whole entry: must never land.
  task automatic test_sw_blocked();
    do_reset();
    @(negedge clk);
    sw_csr_wen = 1; sw_csr_id = 12'h300; sw_csr_wdata = 64'h88;
    ex_valid = 1; ex_ecall = 1; ex_pc = 64'h8000_0090;
    @(negedge clk);
    ex_valid = 0; ex_ecall = 0;
    n_checks++; if (mstatus_o !== 64'h1800) begin n_fail++; $display("FAIL blk_accept: got %h exp 1800", mstatus_o); end
    @(negedge clk); @(negedge clk); @(negedge clk);
    clear_ex();
    n_checks++; if (mstatus_o !== 64'h1800) begin n_fail++; $display("FAIL blk_entry: got %h exp 1800", mstatus_o); end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_back_to_back();
    test_irq_masked();
    test_irq_priority();
    test_reset_mid();
    test_sw_blocked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

- Sequences machine-mode trap entry (`ecall`, optional timer interrupt) and `mret` return for the single-issue core.
- Sits between the execute stage and the CSR register file:
  - stalls the pipeline while active;
  - drives the CSR file's write port to save `mepc` and `mcause` over successive cycles;
  - issues the PC redirect.
- Owns the `mstatus.MIE` and `mstatus.MPIE` bits, which the CSR file does not implement.

## Interface
Parameters:
- `MTVEC_ALIGN_MASK`, default `64'hFFFF_FFFF_FFFF_FFFC`. Mask applied to `mtvec_i` to form the trap vector (direct mode only).

Ports:
- `clk`  in  1  Single clock, rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `ex_valid`  in  1  Execute stage holds a valid instruction.
- `ex_ecall`  in  1  That instruction is `ecall`.
- `ex_mret`  in  1  That instruction is `mret`.
- `ex_pc`  in  64  PC of that instruction.
- `irq_timer`  in  1  Level machine-timer interrupt (used only with `TRAP_CTRL_IRQ_EN`).
- `mtvec_i`  in  64  Current `mtvec` from the CSR file.
- `mepc_i`  in  64  Current `mepc` from the CSR file.
- `sw_csr_wen`  in  1  Software CSR write strobe from execute.
- `sw_csr_id`  in  12  Software CSR write address.
- `sw_csr_wdata`  in  64  Software CSR write data (already op-resolved).
- `stall`  out  1  Freeze fetch/decode/execute.
- `csr_wen`  out  1  Trap-save write strobe to the CSR file.
- `csr_id`  out  12  Trap-save CSR address.
- `csr_wdata`  out  64  Trap-save data.
- `redirect_valid`  out  1  One-cycle PC redirect strobe.
- `redirect_pc`  out  64  Redirect target.
- `mstatus_o`  out  64  Read value of `mstatus`: bit 3 = MIE, bit 7 = MPIE, bits 12:11 = 2'b11, all other bits 0.

## Operation
- States: `IDLE`, `SAVE_EPC`, `SAVE_CAUSE`, `REDIRECT`, `RET`.
- Trap request is evaluated only in `IDLE` with `ex_valid=1`. Priority:
  1. Interrupt: `irq_timer & MIE`.
  2. `ecall`.
  3. `mret`.
- **Accept cycle:**
  - Latches `ex_pc` into `epc_q`.
  - Latches the cause into `cause_q`: `64'h8000_0000_0000_0007` for the interrupt, `64'hB` for `ecall`.
  - Next state is `SAVE_EPC`, or `RET` for `mret`.
- **`SAVE_EPC`:** `csr_wen=1`, `csr_id=12'h341`, `csr_wdata=epc_q`. Same edge: `MPIE<=MIE`, `MIE<=0`.
- **`SAVE_CAUSE`:** `csr_wen=1`, `csr_id=12'h342`, `csr_wdata=cause_q`.
- **`REDIRECT`:** `redirect_valid=1`, `redirect_pc=mtvec_i & MTVEC_ALIGN_MASK`. Next state `IDLE`.
- **`RET`:** `redirect_valid=1`, `redirect_pc=mepc_i`. Same edge: `MIE<=MPIE`, `MPIE<=1`. Next state `IDLE`.
- **Software write** with `sw_csr_wen=1` and `sw_csr_id=12'h300`, accepted only when `stall=0`: `MIE<=wdata[3]`, `MPIE<=wdata[7]`.
- **Simultaneous software write and trap acceptance:** the trap wins and the software write is dropped. The instruction being trapped is not executed.
- **Idle outputs:** when not in the states listed above, `csr_wen=0`, `csr_id=0`, `csr_wdata=0`, `redirect_valid=0`, `redirect_pc=0`.

## Timing
- **Reset:** state=`IDLE`, MIE=0, MPIE=0, `epc_q=0`, `cause_q=0`. All outputs read 0, except `mstatus_o`, which reads `64'h1800`.
- **`stall`** is combinational: 1 in the accept cycle (request decoded in `IDLE`) and in every non-`IDLE` state.
- **Trap entry:** 4 cycles.
  - Cycle 0: accept.
  - Cycle 1: `SAVE_EPC`.
  - Cycle 2: `SAVE_CAUSE`.
  - Cycle 3: `REDIRECT`.
  - Fetch from the vector starts in cycle 4.
- **`mret`:** 2 cycles (accept, then `RET`).
- **`mtvec_i` / `mepc_i`** are sampled combinationally in `REDIRECT` / `RET`. The `mepc` write in cycle 1 is therefore visible by `RET` of any later `mret`.
- **Inputs ignored outside `IDLE`:** `ex_*` and `irq_timer`. An interrupt asserted during a sequence is taken at the next `IDLE` evaluation, if still high and MIE=1.
- **Back-to-back:** a new request may be accepted in the cycle after `REDIRECT` or `RET`.
- **Reset mid-sequence:** returns immediately to `IDLE`, and any partial CSR save is abandoned.

## Configuration
- **`TRAP_CTRL_IRQ_EN` defined:** the timer interrupt path is compiled in as described above.
- **Undefined:**
  - `irq_timer` is unconnected internally.
  - Cause is always `64'hB`.
  - Only `ecall` and `mret` are sequenced.
  - The MIE/MPIE bits still exist and still swap on entry and return.

## Test plan
- **`ecall` entry.** Reset, then `ecall` at `ex_pc=0x8000_0010` with `mtvec_i=0x8000_0103`. Required:
  - cycle 1: `csr_wen`, id `0x341`, data `0x8000_0010`;
  - cycle 2: id `0x342`, data `0xB`;
  - cycle 3: `redirect_pc=0x8000_0100`;
  - `stall` high for cycles 0–3.
- **`mret` return.** Write `mstatus=0x8` (MIE=1), take `ecall`, then `mret` with `mepc_i=0x8000_0014`. Required:
  - after entry, `mstatus_o=0x1880`;
  - after `RET`, `redirect_pc=0x8000_0014` and `mstatus_o=0x1888`.
- **Interrupt priority (IRQ_EN).** MIE=1, `irq_timer=1` together with `ecall`. Required: `mcause` write data `0x8000_0000_0000_0007`, `mepc`=the `ecall` PC.
- **Interrupt masked.** MIE=0, `irq_timer=1`, plain instruction. Required: no stall and no CSR write.
- **Reset mid-sequence.** Assert `rst_n=0` during `SAVE_CAUSE`. Required: outputs 0 asynchronously, `mstatus_o=0x1800`, next `ecall` sequences normally.
- **Blocked software write.** `sw_csr_wen` to `0x300` in the same cycle as `ecall` acceptance. Required: MIE/MPIE follow trap semantics only.
